uart_baud_gen: RTL and testbench

- Parametrised baud-rate generator for the UART transmitter and receiver; the successor to the fixed-ratio toggle divider.
- Derives from clk_in a one-cycle oversample strobe, a mid-bit strobe, a bit strobe, and a 50%-duty divided clock.
- The divisor is runtime-programmable and changes glitch-free at period boundaries.
- Restart input realigns bit phase for RX start-bit detection. Sits between the system clock and the UART TX/RX FSMs.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_mod_counter.sv | 26 ++
 rtl/uart_baud_gen.sv | 104 ++++++++++
 tb/tb_uart_baud_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and divisor helper for the UART baud generator
package uart_pkg;

  localparam int DEF_DIV_W      = 16;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int MIN_DIV        = 2;

  // Rounds clk_freq / (baud * os) to the nearest integer.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    longint step;
    step = longint'(baud) * longint'(os);
    return int'((longint'(clk_freq) + step / 2) / step);
  endfunction

endpackage

// File: rtl/uart_mod_counter.sv
// rtl/uart_mod_counter.sv - modulo counter 0..last with enable, clear and wrap strobe
module uart_mod_counter #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && !clear && (count == last);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == last) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - programmable baud generator: oversample, mid-bit, bit strobes and bit clock
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             tick_os,
  output logic             tick_mid,
  output logic             tick_baud,
  output logic             clk_out,
  output logic             div_err
);

  localparam int                IDX_W     = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_MID   = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0]  DIV_RESET = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(MIN_DIV);

  logic [DIV_W-1:0] div_active;
  logic [DIV_W-1:0] div_pending;
  logic             pend_valid;
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] os_last;
  logic [DIV_W-1:0] os_cnt;
  logic [IDX_W-1:0] os_idx;
  logic             os_wrap;
  logic             idx_wrap;

  assign div_last = div_active - DIV_W'(1);
  // A smaller divisor applied while frozen can leave os_cnt past its end; wrap there on resume.
  assign os_last  = (os_cnt > div_last) ? os_cnt : div_last;

  uart_mod_counter #(.W(DIV_W)) u_os_cnt (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (en),
    .clear  (restart),
    .last   (os_last),
    .count  (os_cnt),
    .wrap   (os_wrap)
  );

  uart_mod_counter #(.W(IDX_W)) u_os_idx (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (os_wrap),
    .clear  (restart),
    .last   (IDX_LAST),
    .count  (os_idx),
    .wrap   (idx_wrap)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_os     <= 1'b0;
      tick_mid    <= 1'b0;
      tick_baud   <= 1'b0;
      clk_out     <= 1'b0;
      div_err     <= 1'b0;
      div_active  <= DIV_RESET;
      div_pending <= DIV_RESET;
      pend_valid  <= 1'b0;
    end else begin
      tick_os   <= os_wrap;
      tick_mid  <= os_wrap && (os_idx == IDX_MID);
      tick_baud <= idx_wrap;

      if (restart) begin
        clk_out <= 1'b0;
      end else if (os_wrap && ((os_idx == IDX_MID) || idx_wrap)) begin
        clk_out <= ~clk_out;
      end

      // Pending divisor lands only where no period is in flight.
      if (pend_valid && (os_wrap || !en || restart)) begin
        div_active <= div_pending;
        pend_valid <= 1'b0;
      end

      if (div_load) begin
        pend_valid <= 1'b1;
        if (div_value < DIV_MIN) begin
          div_pending <= DIV_MIN;
          div_err     <= 1'b1;
        end else begin
          div_pending <= div_value;
          div_err     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - self-checking bench for uart_baud_gen with a cycle scoreboard
module tb_uart_baud_gen;

  localparam int OS = 4;
  localparam int DD = 4;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_value = 16'd0;
  logic        tick_os, tick_mid, tick_baud, clk_out, div_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [4:0] exp_q[$];
  int         m_cnt = 0, m_idx = 0, m_act = DD, m_pend = DD;
  bit         m_pv = 1'b0;
  logic [4:0] m_out = 5'd0;

  uart_baud_gen #(.OVERSAMPLE(OS), .DEFAULT_DIV(DD)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .restart   (restart),
    .div_load  (div_load),
    .div_value (div_value),
    .tick_os   (tick_os),
    .tick_mid  (tick_mid),
    .tick_baud (tick_baud),
    .clk_out   (clk_out),
    .div_err   (div_err)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference model: expected {tick_os, tick_mid, tick_baud, clk_out, div_err} after each edge.
  always @(posedge clk_in or negedge rst_n) begin : model
    int         cnt, idx, act, pend;
    bit         pv, wrap;
    logic [4:0] o;
    if (!rst_n) begin
      cnt = 0; idx = 0; act = DD; pend = DD; pv = 1'b0; o = 5'd0;
      exp_q.delete();
    end else begin
      cnt = m_cnt; idx = m_idx; act = m_act; pend = m_pend; pv = m_pv;
      o = {3'b000, m_out[1], m_out[0]};
      wrap = en && !restart && (m_cnt == m_act - 1);
      if (restart) begin
        cnt = 0; idx = 0; o[1] = 1'b0;
      end else if (en) begin
        if (wrap) begin
          cnt = 0;
          o[4] = 1'b1;
          o[3] = (m_idx == OS / 2 - 1);
          o[2] = (m_idx == OS - 1);
          if (o[3] || o[2]) o[1] = ~o[1];
          idx = (m_idx == OS - 1) ? 0 : m_idx + 1;
        end else begin
          cnt = m_cnt + 1;
        end
      end
      if (m_pv && (wrap || !en || restart)) begin
        act = m_pend; pv = 1'b0;
      end
      if (div_load) begin
        pend = (div_value < 2) ? 2 : int'(div_value);
        pv = 1'b1;
        o[0] = (div_value < 2);
      end
    end
    m_cnt <= cnt; m_idx <= idx; m_act <= act; m_pend <= pend; m_pv <= pv; m_out <= o;
    exp_q.push_back(o);
  end

  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({tick_os, tick_mid, tick_baud, clk_out, div_err} !== e) begin
        failures++;
        $display("FAIL scoreboard cyc=%0d got=%b expected=%b", cyc,
                 {tick_os, tick_mid, tick_baud, clk_out, div_err}, e);
      end
    end
  end

  task automatic wait_os(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (tick_os === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL wait_os timeout at cyc=%0d", cyc);
    end
  endtask

  task automatic load_div(input logic [15:0] v);
    @(posedge clk_in); #1 div_load = 1'b1; div_value = v;
    @(posedge clk_in); #1 div_load = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({tick_os, tick_mid, tick_baud, clk_out, div_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=00000", {tick_os, tick_mid, tick_baud, clk_out, div_err});
    end
  endtask

  task automatic test_default;
    int a, b, hi;
    @(posedge clk_in); #1 en = 1'b1; rst_n = 1'b1;
    a = cyc;
    for (int k = 0; k < 8; k++) begin
      wait_os(b);
      checks++;
      if (b - a !== 4) begin
        failures++; $display("FAIL default_gap k=%0d got=%0d expected=4", k, b - a);
      end
      checks++;
      if (tick_mid !== (k % 4 == 1) || tick_baud !== (k % 4 == 3)) begin
        failures++;
        $display("FAIL default_phase k=%0d got mid=%b baud=%b", k, tick_mid, tick_baud);
      end
      a = b;
    end
    hi = 0;
    repeat (16) begin
      @(negedge clk_in);
      hi += int'(clk_out);
    end
    checks++;
    if (hi !== 8) begin
      failures++; $display("FAIL clk_out_duty got=%0d expected=8", hi);
    end
  endtask

  task automatic test_div_change;
    int a, b, c, d;
    wait_os(a);
    load_div(16'd6);
    wait_os(b); wait_os(c); wait_os(d);
    checks++;
    if (b - a !== 4 || c - b !== 6 || d - c !== 6) begin
      failures++; $display("FAIL div_change gaps got=%0d,%0d,%0d expected=4,6,6", b - a, c - b, d - c);
    end
    checks++;
    if (div_err !== 1'b0) begin
      failures++; $display("FAIL div_change_err got=%b expected=0", div_err);
    end
  endtask

  task automatic test_illegal_div;
    int a, b, c, d, e, f, g;
    wait_os(a);
    @(posedge clk_in); #1 div_load = 1'b1; div_value = 16'd1;
    @(posedge clk_in); #1 div_value = 16'd0;
    @(posedge clk_in); #1 div_load = 1'b0;
    @(negedge clk_in);
    checks++;
    if (div_err !== 1'b1) begin
      failures++; $display("FAIL illegal_err got=%b expected=1", div_err);
    end
    wait_os(b); wait_os(c); wait_os(d);
    checks++;
    if (c - b !== 2 || d - c !== 2) begin
      failures++; $display("FAIL illegal_gap got=%0d,%0d expected=2,2", c - b, d - c);
    end
    load_div(16'd5);
    wait_os(e); wait_os(f); wait_os(g);
    checks++;
    if (g - f !== 5) begin
      failures++; $display("FAIL legal_after_illegal_gap got=%0d expected=5", g - f);
    end
    checks++;
    if (div_err !== 1'b0) begin
      failures++; $display("FAIL legal_clears_err got=%b expected=0", div_err);
    end
  endtask

  task automatic test_restart;
    int a, rc, t;
    load_div(16'd4);
    repeat (3) wait_os(a);
    repeat (3) @(posedge clk_in);
    #1 restart = 1'b1;
    @(posedge clk_in); #1 restart = 1'b0;
    rc = cyc;
    @(negedge clk_in);
    checks++;
    if (tick_os !== 1'b0 || clk_out !== 1'b0) begin
      failures++; $display("FAIL restart_on_wrap got tick_os=%b clk_out=%b expected=0,0", tick_os, clk_out);
    end
    for (int k = 1; k <= 4; k++) begin
      wait_os(t);
      checks++;
      if (t - rc !== 4 * k || tick_baud !== (k == 4)) begin
        failures++;
        $display("FAIL restart_tick k=%0d got offset=%0d baud=%b expected offset=%0d", k, t - rc, tick_baud, 4 * k);
      end
    end
  endtask

  task automatic test_freeze;
    int r, t;
    logic hold;
    @(posedge clk_in); #1 restart = 1'b1;
    @(posedge clk_in); #1 restart = 1'b0;
    r = cyc;
    repeat (6) @(posedge clk_in);
    #1 en = 1'b0;
    hold = clk_out;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      checks++;
      if (tick_os !== 1'b0 || tick_mid !== 1'b0 || tick_baud !== 1'b0 || clk_out !== hold) begin
        failures++; $display("FAIL freeze i=%0d got tick_os=%b clk_out=%b", i, tick_os, clk_out);
      end
    end
    @(posedge clk_in); #1 en = 1'b1;
    wait_os(t);
    checks++;
    if (t - r !== 15 || tick_mid !== 1'b1) begin
      failures++; $display("FAIL freeze_resume got offset=%0d mid=%b expected offset=15 mid=1", t - r, tick_mid);
    end
  endtask

  task automatic test_reset_mid;
    int a, b, c, rel;
    load_div(16'd6);
    wait_os(a); wait_os(b); wait_os(c);
    checks++;
    if (c - b !== 6) begin
      failures++; $display("FAIL pre_reset_gap got=%0d expected=6", c - b);
    end
    @(posedge clk_in); #1 div_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tick_os, tick_mid, tick_baud, clk_out, div_err} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset got=%b expected=00000", {tick_os, tick_mid, tick_baud, clk_out, div_err});
    end
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    rel = cyc;
    wait_os(a); wait_os(b);
    checks++;
    if (a - rel !== 4 || b - a !== 4) begin
      failures++; $display("FAIL post_reset_gap got=%0d,%0d expected=4,4", a - rel, b - a);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_div_change();
    test_illegal_div();
    test_restart();
    test_freeze();
    test_reset_mid();
    repeat (2) @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
